// File: rtl/ps2_keycode_decoder.sv
`default_nettype none
// ============================================================================
// Module  : ps2_keycode_decoder
// Brief   : PS/2 Set-2 scancode stream to ASCII, with prefix/modifier tracking
//           and a first-word-fall-through output FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module ps2_keycode_decoder #(
  parameter int FIFO_DEPTH   = 8,
  parameter bit CAPS_LOCK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code_in,
  input  logic       code_valid,
  output logic [7:0] ascii_out,
  output logic       ascii_valid,
  input  logic       ascii_ready,
  output logic       shift_state,
  output logic       caps_state,
  output logic       overflow
);

  localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(FIFO_DEPTH);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_EXT     = 2'd1;
  localparam logic [1:0] c_ST_BRK     = 2'd2;
  localparam logic [1:0] c_ST_EXT_BRK = 2'd3;

  logic [1:0]      r_state;
  logic            r_lshift;
  logic            r_rshift;
  logic            r_caps;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_CW-1:0] r_count;
  logic            r_overflow;

  logic       w_shift;
  logic [7:0] w_lower;
  logic [7:0] w_other;
  logic       w_is_letter;
  logic       w_mapped;
  logic [7:0] w_char;
  logic       w_make;
  logic       w_push_req;
  logic       w_full;
  logic       w_pop;
  logic       w_push;

  assign w_shift = r_lshift | r_rshift;

  always_comb begin
    w_lower = 8'h00;
    case (code_in)
      8'h1C: w_lower = "a";
      8'h32: w_lower = "b";
      8'h21: w_lower = "c";
      8'h23: w_lower = "d";
      8'h24: w_lower = "e";
      8'h2B: w_lower = "f";
      8'h34: w_lower = "g";
      8'h33: w_lower = "h";
      8'h43: w_lower = "i";
      8'h3B: w_lower = "j";
      8'h42: w_lower = "k";
      8'h4B: w_lower = "l";
      8'h3A: w_lower = "m";
      8'h31: w_lower = "n";
      8'h44: w_lower = "o";
      8'h4D: w_lower = "p";
      8'h15: w_lower = "q";
      8'h2D: w_lower = "r";
      8'h1B: w_lower = "s";
      8'h2C: w_lower = "t";
      8'h3C: w_lower = "u";
      8'h2A: w_lower = "v";
      8'h1D: w_lower = "w";
      8'h22: w_lower = "x";
      8'h35: w_lower = "y";
      8'h1A: w_lower = "z";
      default: w_lower = 8'h00;
    endcase
  end

  // Digits honour shift only; caps lock never reaches this table.
  always_comb begin
    w_other = 8'h00;
    case (code_in)
      8'h16: w_other = w_shift ? "!" : "1";
      8'h1E: w_other = w_shift ? "@" : "2";
      8'h26: w_other = w_shift ? "#" : "3";
      8'h25: w_other = w_shift ? "$" : "4";
      8'h2E: w_other = w_shift ? "%" : "5";
      8'h36: w_other = w_shift ? "^" : "6";
      8'h3D: w_other = w_shift ? "&" : "7";
      8'h3E: w_other = w_shift ? "*" : "8";
      8'h46: w_other = w_shift ? "(" : "9";
      8'h45: w_other = w_shift ? ")" : "0";
      8'h29: w_other = 8'h20;
      8'h5A: w_other = 8'h0D;
      8'h66: w_other = 8'h08;
      8'h0D: w_other = 8'h09;
      default: w_other = 8'h00;
    endcase
  end

  assign w_is_letter = (w_lower != 8'h00);
  assign w_mapped    = w_is_letter | (w_other != 8'h00);
  assign w_char      = w_is_letter ? ((w_shift ^ r_caps) ? (w_lower - 8'h20) : w_lower)
                                   : w_other;

  assign w_make     = code_valid && (r_state == c_ST_IDLE) &&
                      (code_in != 8'hE0) && (code_in != 8'hF0);
  assign w_push_req = w_make && w_mapped;
  assign w_full     = (r_count == c_FULL_CNT);
  assign w_pop      = ascii_valid && ascii_ready;
  assign w_push     = w_push_req && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_ST_IDLE;
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
      r_caps   <= 1'b0;
    end else if (code_valid) begin
      case (r_state)
        c_ST_IDLE: begin
          if (code_in == 8'hE0) begin
            r_state <= c_ST_EXT;
          end else if (code_in == 8'hF0) begin
            r_state <= c_ST_BRK;
          end else begin
            if (code_in == 8'h12) r_lshift <= 1'b1;
            if (code_in == 8'h59) r_rshift <= 1'b1;
            if ((code_in == 8'h58) && CAPS_LOCK_EN) r_caps <= ~r_caps;
          end
        end
        c_ST_EXT: begin
          if (code_in == 8'hF0)      r_state <= c_ST_EXT_BRK;
          else if (code_in == 8'hE0) r_state <= c_ST_EXT;
          else                       r_state <= c_ST_IDLE;
        end
        c_ST_BRK: begin
          r_state <= c_ST_IDLE;
          if (code_in == 8'h12) r_lshift <= 1'b0;
          if (code_in == 8'h59) r_rshift <= 1'b0;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  // Storage is reset too, so the head reads 0x00 after reset and stays stable when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_push_req && w_full && !w_pop;
      if (w_push) begin
        r_mem[r_wptr] <= w_char;
        r_wptr        <= r_wptr + c_AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign ascii_out   = r_mem[r_rptr];
  assign ascii_valid = (r_count != '0);
  assign shift_state = w_shift;
  assign caps_state  = r_caps;
  assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keycode_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_ps2_keycode_decoder
// Brief   : Scoreboard bench; two decoders (caps lock enabled / disabled) share stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ps2_keycode_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] code_in;
  logic       code_valid;
  logic       ascii_ready;

  logic [7:0] out_a, out_b;
  logic       valid_a, valid_b, shift_a, shift_b, caps_a, caps_b, ovf_a, ovf_b;

  int n_cmp = 0;
  int n_err = 0;
  int ovf_cnt_a = 0;
  int ovf_cnt_b = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  always #5 clk = ~clk;

  ps2_keycode_decoder #(.FIFO_DEPTH(8), .CAPS_LOCK_EN(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .ascii_out(out_a), .ascii_valid(valid_a), .ascii_ready(ascii_ready),
    .shift_state(shift_a), .caps_state(caps_a), .overflow(ovf_a));

  ps2_keycode_decoder #(.FIFO_DEPTH(8), .CAPS_LOCK_EN(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .ascii_out(out_b), .ascii_valid(valid_b), .ascii_ready(ascii_ready),
    .shift_state(shift_b), .caps_state(caps_b), .overflow(ovf_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare the head against the scoreboard whenever a pop will happen.
  always @(negedge clk) begin
    if (!rst) begin
      if (ovf_a) ovf_cnt_a++;
      if (ovf_b) ovf_cnt_b++;
      if (valid_a && ascii_ready) begin
        if (q_a.size() == 0) chk("a_unexpected_char", {24'h0, out_a}, 32'hFFFF_FFFF);
        else chk("a_char", {24'h0, out_a}, {24'h0, q_a.pop_front()});
      end
      if (valid_b && ascii_ready) begin
        if (q_b.size() == 0) chk("b_unexpected_char", {24'h0, out_b}, 32'hFFFF_FFFF);
        else chk("b_char", {24'h0, out_b}, {24'h0, q_b.pop_front()});
      end
    end
  end

  task automatic exp2(input logic [7:0] a, input logic [7:0] b);
    q_a.push_back(a);
    q_b.push_back(b);
  endtask

  task automatic exp1(input logic [7:0] c);
    exp2(c, c);
  endtask

  // Leaves code_valid high so consecutive sends are back to back.
  task automatic send(input logic [7:0] c);
    @(posedge clk); #1;
    code_in    = c;
    code_valid = 1'b1;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    code_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] codes5 [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
  logic [7:0] chars5 [9] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};
  logic [7:0] codes6 [20] = '{8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15,
                              8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35,
                              8'h1A, 8'h16, 8'h1E, 8'h26};
  logic [7:0] chars6 [20] = '{8'h6A, 8'h6B, 8'h6C, 8'h6D, 8'h6E, 8'h6F, 8'h70, 8'h71,
                              8'h72, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77, 8'h78, 8'h79,
                              8'h7A, 8'h31, 8'h32, 8'h33};

  initial begin
    int base;
    rst         = 1'b1;
    code_in     = 8'h00;
    code_valid  = 1'b0;
    ascii_ready = 1'b0;
    wait_cycles(3);
    rst = 1'b0;
    #1;
    chk("rst_valid", {31'h0, valid_a}, 0);
    chk("rst_out", {24'h0, out_a}, 0);
    chk("rst_shift", {31'h0, shift_a}, 0);
    chk("rst_caps", {31'h0, caps_a}, 0);
    chk("rst_overflow", {31'h0, ovf_a}, 0);

    // Single press: latency and pop
    exp1(8'h61);
    send(8'h1C); idle();
    chk("lat_valid", {31'h0, valid_a}, 1);
    chk("lat_out", {24'h0, out_a}, 32'h61);
    ascii_ready = 1'b1;
    wait_cycles(1);
    ascii_ready = 1'b0;
    chk("pop_valid_low", {31'h0, valid_a}, 0);
    ascii_ready = 1'b1;

    // Shift press/release, break codes silent
    send(8'h12); idle();
    chk("shift_set", {31'h0, shift_a}, 1);
    exp1(8'h41);
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12); idle();
    chk("shift_clr", {31'h0, shift_a}, 0);
    exp1(8'h61);
    send(8'h1C); idle();
    send(8'h59); idle();
    chk("rshift_set", {31'h0, shift_b}, 1);
    send(8'hF0); send(8'h59); idle();
    chk("rshift_clr", {31'h0, shift_b}, 0);

    // Caps lock on instance A, ignored on instance B
    send(8'h58); idle();
    chk("caps_on_a", {31'h0, caps_a}, 1);
    chk("caps_off_b", {31'h0, caps_b}, 0);
    exp2(8'h41, 8'h61);
    send(8'h1C);
    send(8'h12);
    exp2(8'h61, 8'h41);
    send(8'h1C);
    exp1(8'h21);
    send(8'h16);
    send(8'hF0); send(8'h12); send(8'h58); idle();
    chk("caps_toggle_back", {31'h0, caps_a}, 0);

    // Extended prefixes, control characters, unmapped code
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'hE0); send(8'h75);
    send(8'hE0); send(8'h12); idle();
    chk("ext_no_shift", {31'h0, shift_a}, 0);
    exp1(8'h20); send(8'h29);
    exp1(8'h0D); send(8'h5A);
    exp1(8'h08); send(8'h66);
    exp1(8'h09); send(8'h0D);
    send(8'h05); idle();
    wait_cycles(4);

    // Reset after F0 discards the break prefix
    send(8'hF0); idle();
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    chk("midrst_valid", {31'h0, valid_a}, 0);
    exp1(8'h61);
    send(8'h1C); idle();
    wait_cycles(3);

    // Overflow on ninth push, then drain in order
    ascii_ready = 1'b0;
    base = ovf_cnt_a;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp1(chars5[i]);
      send(codes5[i]);
    end
    idle();
    chk("ovf_pulse", {31'h0, ovf_a}, 1);
    wait_cycles(1);
    chk("ovf_one_cycle", {31'h0, ovf_a}, 0);
    chk("ovf_count", ovf_cnt_a - base, 1);
    chk("ovf_full_valid", {31'h0, valid_a}, 1);
    ascii_ready = 1'b1;
    wait_cycles(12);
    chk("drain_empty", {31'h0, valid_a}, 0);

    // Full FIFO with simultaneous pop and push, wrapping over 20 characters
    ascii_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp1(chars6[i]);
      send(codes6[i]);
    end
    idle();
    base = ovf_cnt_a + ovf_cnt_b;
    for (int i = 8; i < 20; i++) begin
      exp1(chars6[i]);
      send(codes6[i]);
      ascii_ready = 1'b1;
    end
    idle();
    chk("wrap_still_full", {31'h0, valid_a}, 1);
    chk("wrap_no_ovf", (ovf_cnt_a + ovf_cnt_b) - base, 0);
    wait_cycles(12);
    chk("wrap_empty", {31'h0, valid_a}, 0);

    chk("queue_a_empty", q_a.size(), 0);
    chk("queue_b_empty", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_keycode_decoder.md
Name: ps2_keycode_decoder

Overview:
Sequential successor to the combinational scancode-to-ASCII lookup. It consumes a stream of PS/2 Set-2 scancode bytes from the PS/2 receiver and tracks prefix state (E0 extended, F0 break). It also tracks modifier state (left/right shift, caps lock) and pushes the ASCII value of each key press into a parametrised output FIFO with a valid/ready handshake. It sits between the PS/2 byte receiver and consumers such as the UART TX path or the text display.

Parameters:
FIFO_DEPTH, 8, output FIFO entries; must be a power of two, 2..64
CAPS_LOCK_EN, 1, 1 = scancode 0x58 toggles caps lock; 0 = 0x58 ignored and caps_state held at 0

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
code_in  input  8  scancode byte from PS/2 receiver
code_valid  input  1  one-cycle strobe; code_in valid this cycle
ascii_out  output  8  ASCII character at FIFO head
ascii_valid  output  1  FIFO non-empty
ascii_ready  input  1  consumer accepts head when ascii_valid && ascii_ready
shift_state  output  1  either shift key currently held
caps_state  output  1  caps lock toggled on
overflow  output  1  one-cycle pulse; a character was dropped because the FIFO was full

Behaviour:
- Reset: synchronous, active-high, on the clk rising edge. Clears the FSM to IDLE, both shift flags, caps, the FIFO pointers and count, and overflow. Outputs after reset: ascii_valid=0, ascii_out=0x00, shift_state=0, caps_state=0, overflow=0. Reset asserted mid-sequence (for example after F0) discards the pending prefix.
- Prefix FSM, advancing only on code_valid:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte is a make code -> process make, stay IDLE.
  - EXT: F0 -> EXT_BRK; any other byte is an extended make -> IDLE, no output, no modifier change.
  - BRK: any byte is a break of that code -> IDLE. 0x12 clears lshift; 0x59 clears rshift; all other codes produce no output.
  - EXT_BRK: any byte -> IDLE, no effect.
  - A repeated E0 while in EXT stays in EXT.
- Make processing:
  - 0x12 sets lshift; 0x59 sets rshift. shift_state = lshift | rshift.
  - 0x58 toggles caps when CAPS_LOCK_EN=1. Typematic repeats of 0x58 toggle again; no repeat filtering.
  - Modifier make codes produce no FIFO push.
- ASCII mapping, make codes only:
  - Letters 0x1C,0x32,0x21,...: lowercase 'a'-'z'; uppercase when (shift XOR caps).
  - Digits 0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46,0x45 -> '1'..'9','0'. With shift -> ! @ # $ % ^ & * ( ). Caps does not affect digits.
  - 0x29 -> 0x20 (space); 0x5A -> 0x0D (enter); 0x66 -> 0x08 (backspace); 0x0D -> 0x09 (tab).
  - Unmapped codes produce no push.
- Latency: a mapped make byte strobed in cycle N is written to the FIFO at the end of N. If the FIFO was empty, ascii_valid=1 and ascii_out holds the character in cycle N+1. The FIFO is first-word-fall-through with registered status.
- FIFO behaviour:
  - Push and pop in the same cycle: both happen; count unchanged. When full, the same-cycle pop frees the slot, so the push succeeds with no overflow.
  - Push when full with no pop: character dropped, overflow=1 for one cycle, FIFO contents unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - ascii_out holds its value while ascii_valid=0; the value is don't-care, but it must be stable.
- Modifier flags update in the same cycle the code is consumed. A make in the following cycle already sees the new shift/caps.

Test Plan:
- Reset then code_valid bytes 1C -> one push; ascii_out=0x61 ('a') one cycle later; ascii_valid drops after a pop with ascii_ready=1.
- Bytes 12, 1C, F0 1C, F0 12, 1C -> FIFO holds 0x41, 0x61; shift_state=1 after 12 and 0 after F0 12; break bytes produce no push.
- Bytes 58, 1C, 12, 1C, 16 with CAPS_LOCK_EN=1 -> caps_state=1; FIFO holds 0x41, 0x61, 0x21. Repeat with CAPS_LOCK_EN=0 -> 0x61, 0x41, 0x21.
- Extended handling: E0 75, E0 F0 75, then 29 -> only 0x20 pushed; FSM back in IDLE. Also F0 sent, then rst pulsed, then 1C -> 0x61 pushed, since the break prefix was discarded.
- FIFO_DEPTH=8, ascii_ready=0, nine mapped makes -> first eight retained in order; overflow pulses exactly once on the ninth. Then drain with ascii_ready=1 -> eight characters in order, ascii_valid falls after the last.
- Full FIFO with ascii_ready=1 and a new make in the same cycle -> pop and push both occur, no overflow, count stays 8; wrap-around order verified over 20 characters.
